pin_motor_seq: RTL

PIN_MOTOR_SEQ -- requirements
Module: pin_motor_seq

---
 rtl/pin_motor_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pin_motor_seq.sv
// pin_motor_seq: sequences a pin motor through pull / hold / loosen.
// A start in IDLE drives the motor backward (pull) until PULL_CYCLES
// elapse or the end-stop closes, holds at STOP for HOLD_CYCLES, then
// drives forward (loosen) for LOOSEN_CYCLES. An abort in any active
// phase stops the motor and waits DEAD_CYCLES after abort drops.
//
// State table:
//   state  | meaning
//   IDLE   | motor stopped, waiting for start
//   PULL   | motor backward, pulling the pin
//   HOLD   | motor stopped between pull and loosen
//   LOOSEN | motor forward, loosening the pin
//   BRAKE  | motor stopped after abort, dead time running
//
// Ports:
//   clk          in   single clock
//   rst          in   synchronous active-high reset
//   start        in   single-cycle request to run one sequence
//   abort        in   level request to stop the motor
//   limit_pulled in   end-stop, 1 = pin fully pulled (pre-synchronised)
//   motor_state  out  00 STOP, 01 FORWARD, 10 BACKWARD
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on normal completion
//   aborted      out  one-cycle pulse when the abort dead time ends
//   early_stop   out  sticky, last pull ended on the end-stop
module pin_motor_seq #(
  parameter int unsigned PULL_CYCLES   = 50_000_000,
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned LOOSEN_CYCLES = 30_000_000,
  parameter int unsigned DEAD_CYCLES   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       limit_pulled,
  output logic [1:0] motor_state,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       early_stop
);

  typedef enum logic [2:0] {IDLE, PULL, HOLD, LOOSEN, BRAKE} state_t;

  localparam logic [1:0] MS_STOP = 2'b00;
  localparam logic [1:0] MS_FWD  = 2'b01;
  localparam logic [1:0] MS_BWD  = 2'b10;

  // Counter value seen in the final cycle of each phase.
  localparam logic [31:0] PULL_LAST   = 32'(PULL_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] LOOSEN_LAST = 32'(LOOSEN_CYCLES - 1);
  localparam logic [31:0] DEAD_LAST   = 32'(DEAD_CYCLES - 1);

  state_t      state;
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      motor_state <= MS_STOP;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      early_stop  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state       <= PULL;
            cnt         <= '0;
            motor_state <= MS_BWD;
            busy        <= 1'b1;
            early_stop  <= 1'b0;
          end
        end
        PULL: begin
          if (abort) begin
            state       <= BRAKE;
            cnt         <= '0;
            motor_state <= MS_STOP;
          end else if (limit_pulled || cnt == PULL_LAST) begin
            state       <= HOLD;
            cnt         <= '0;
            motor_state <= MS_STOP;
            if (limit_pulled) early_stop <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HOLD: begin
          if (abort) begin
            state       <= BRAKE;
            cnt         <= '0;
            motor_state <= MS_STOP;
          end else if (cnt == HOLD_LAST) begin
            state       <= LOOSEN;
            cnt         <= '0;
            motor_state <= MS_FWD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LOOSEN: begin
          if (abort) begin
            state       <= BRAKE;
            cnt         <= '0;
            motor_state <= MS_STOP;
          end else if (cnt == LOOSEN_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            motor_state <= MS_STOP;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        BRAKE: begin
          // Dead time restarts for as long as abort stays high.
          if (abort) begin
            cnt <= '0;
          end else if (cnt == DEAD_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          motor_state <= MS_STOP;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
